// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC interpolating feeder.
package dac_pkg;

  localparam int unsigned DAC_BW       = 14;
  localparam int unsigned DAC_OSR_LOG2 = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    UNDERRUN
  } state_t;

  // One guard bit above the scaled sample so prev + p*delta never wraps.
  function automatic int unsigned acc_width(input int unsigned bw, input int unsigned osr_log2);
    return bw + osr_log2 + 1;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Small synchronous FIFO holding incoming PCM samples; flags come from the registered count.
module dac_sample_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dac_interp_feeder.sv
// Upsampling feeder for the delta-sigma DAC: buffered PCM in, one BW-bit word per clock out.
// Define DAC_LINEAR_INTERP_EN for linear interpolation; otherwise the output is a zero-order hold.
module dac_interp_feeder
  import dac_pkg::*;
#(
  parameter int unsigned BW         = DAC_BW,
  parameter int unsigned OSR_LOG2   = DAC_OSR_LOG2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic [BW-1:0] dac_data_o,
  output logic          underrun_o,
  output logic          running_o
);
  localparam int unsigned AW = acc_width(BW, OSR_LOG2);

  state_t               state;
  state_t               next_state;
  logic [OSR_LOG2-1:0]  phase;
  logic                 boundary;
  logic                 pop;
  logic                 reload;
  logic                 underrun_set;
  logic [BW-1:0]        head;
  logic                 full;
  logic                 empty;
  logic signed [BW-1:0] cur;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] cur_scaled;
`ifdef DAC_LINEAR_INTERP_EN
  localparam int unsigned DW = BW + 1;
  logic signed [DW-1:0] delta;
  logic signed [DW-1:0] delta_next;
`else
  logic signed [AW-1:0] head_scaled;
`endif

  dac_sample_fifo #(
    .WIDTH(BW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (s_valid_i),
    .pop   (pop),
    .wdata (s_data_i),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign s_ready_o  = !full;
  assign boundary   = (phase == '1);
  assign cur_scaled = AW'(cur) <<< OSR_LOG2;
`ifdef DAC_LINEAR_INTERP_EN
`else
  assign head_scaled = AW'($signed(head)) <<< OSR_LOG2;
`endif

  // State register; running_o is the registered decode of the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      running_o <= 1'b0;
    end else begin
      state     <= next_state;
      running_o <= (next_state == RUN);
    end
  end

  // Transitions only happen on the boundary edge.
  always_comb begin
    next_state = state;
    if (boundary) begin
      if (!empty)            next_state = RUN;
      else if (state == RUN) next_state = UNDERRUN;
    end
  end

  always_comb begin
    pop          = 1'b0;
    reload       = 1'b0;
    underrun_set = 1'b0;
    if (boundary) begin
      if (!empty) begin
        pop = 1'b1;
      end else if (state == RUN) begin
        reload       = 1'b1;
        underrun_set = 1'b1;
      end
    end
  end

  // Accumulator: reload at boundaries, otherwise step by delta toward the newest sample.
  always_comb begin
    acc_next = acc;
`ifdef DAC_LINEAR_INTERP_EN
    delta_next = delta;
    if (pop) begin
      acc_next   = cur_scaled;
      delta_next = DW'($signed(head)) - DW'(cur);
    end else if (reload) begin
      acc_next   = cur_scaled;
      delta_next = '0;
    end else begin
      acc_next = acc + AW'(delta);
    end
`else
    if (pop)         acc_next = head_scaled;
    else if (reload) acc_next = cur_scaled;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase      <= '0;
      cur        <= '0;
      acc        <= '0;
      dac_data_o <= '0;
      underrun_o <= 1'b0;
`ifdef DAC_LINEAR_INTERP_EN
      delta      <= '0;
`endif
    end else begin
      phase      <= phase + OSR_LOG2'(1);
      acc        <= acc_next;
      dac_data_o <= BW'(acc_next >>> OSR_LOG2);
      underrun_o <= underrun_set;
      if (pop) cur <= $signed(head);
`ifdef DAC_LINEAR_INTERP_EN
      delta      <= delta_next;
`endif
    end
  end

endmodule

// File: tb/tb_dac_interp_feeder.sv
// Directed bench for dac_interp_feeder at BW=14, OSR_LOG2=2, FIFO_DEPTH=4.
// Expected outputs cover both builds (DAC_LINEAR_INTERP_EN defined or not).
module tb_dac_interp_feeder;

`ifdef DAC_LINEAR_INTERP_EN
  localparam bit LIN = 1'b1;
`else
  localparam bit LIN = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic [13:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [13:0] dac_data_o;
  logic        underrun_o;
  logic        running_o;

  int checks;
  int errors;

  typedef struct {
    logic rst;
    logic valid;
    int   data;
    int   lin;
    int   zoh;
    logic und;
    logic run;
    logic rdy;
  } vec_t;

  vec_t vecs[$];

  dac_interp_feeder #(
    .BW(14),
    .OSR_LOG2(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_data_i   (s_data_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .dac_data_o (dac_data_o),
    .underrun_o (underrun_o),
    .running_o  (running_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input int d, input int lin, input int zoh,
                     input logic u, input logic run, input logic rdy);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.lin = lin; t.zoh = zoh;
    t.und = u; t.run = run; t.rdy = rdy;
    vecs.push_back(t);
  endtask

  int bp_dat [6] = '{1000, -2000, 3000, -4000, 5000, 6000};
  bit bp_rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int bp_lin [5] = '{1000, -2000, 3000, -4000, 5000};
  int bp_zoh [5] = '{-2000, 3000, -4000, 5000, 5000};

  initial begin
    int n_acc;
    checks    = 0;
    errors    = 0;
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = '0;

    // Ramp from reset: 0 -> 400, then underrun at the following boundary
    add(1,0,0,     0,   0,0,0,1);
    add(0,1,400,   0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0, 400,0,1,1);
    add(0,0,0,   100, 400,0,1,1);
    add(0,0,0,   200, 400,0,1,1);
    add(0,0,0,   300, 400,0,1,1);
    add(0,0,0,   400, 400,1,0,1);
    add(0,0,0,   400, 400,0,0,1);
    // Negative step 400 -> -400
    add(1,0,0,     0,   0,0,0,1);
    add(0,1,400,   0,   0,0,0,1);
    add(0,1,-400,  0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0, 400,0,1,1);
    add(0,0,0,   100, 400,0,1,1);
    add(0,0,0,   200, 400,0,1,1);
    add(0,0,0,   300, 400,0,1,1);
    add(0,0,0,   400,-400,0,1,1);
    add(0,0,0,   200,-400,0,1,1);
    add(0,0,0,     0,-400,0,1,1);
    add(0,0,0,  -200,-400,0,1,1);
    add(0,0,0,  -400,-400,1,0,1);
    // Full-scale extremes 8191 -> -8192
    add(1,0,0,     0,   0,0,0,1);
    add(0,1,8191,  0,   0,0,0,1);
    add(0,1,-8192, 0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0, 8191,0,1,1);
    add(0,0,0,  2047, 8191,0,1,1);
    add(0,0,0,  4095, 8191,0,1,1);
    add(0,0,0,  6143, 8191,0,1,1);
    add(0,0,0,  8191,-8192,0,1,1);
    add(0,0,0,  4095,-8192,0,1,1);
    add(0,0,0,    -1,-8192,0,1,1);
    add(0,0,0, -4097,-8192,0,1,1);
    add(0,0,0, -8192,-8192,1,0,1);
    // Reset at phase 2 of a ramp with one sample still queued
    add(1,0,0,     0,   0,0,0,1);
    add(0,1,400,   0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0, 400,0,1,1);
    add(0,1,300, 100, 400,0,1,1);
    add(0,0,0,   200, 400,0,1,1);
    add(1,0,0,     0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    // Underrun, hold, resume from the held value; push+pop on one edge
    add(1,0,0,     0,   0,0,0,1);
    add(0,1,400,   0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0,   0,0,0,1);
    add(0,0,0,     0, 400,0,1,1);
    add(0,0,0,   100, 400,0,1,1);
    add(0,0,0,   200, 400,0,1,1);
    add(0,0,0,   300, 400,0,1,1);
    add(0,0,0,   400, 400,1,0,1);
    add(0,0,0,   400, 400,0,0,1);
    add(0,0,0,   400, 400,0,0,1);
    add(0,0,0,   400, 400,0,0,1);
    add(0,0,0,   400, 400,0,0,1);
    add(0,1,0,   400, 400,0,0,1);
    add(0,0,0,   400, 400,0,0,1);
    add(0,0,0,   400, 400,0,0,1);
    add(0,1,800, 400,   0,0,1,1);
    add(0,0,0,   300,   0,0,1,1);
    add(0,0,0,   200,   0,0,1,1);
    add(0,0,0,   100,   0,0,1,1);
    add(0,0,0,     0, 800,0,1,1);
    add(0,0,0,   200, 800,0,1,1);
    add(0,0,0,   400, 800,0,1,1);
    add(0,0,0,   600, 800,0,1,1);
    add(0,0,0,   800, 800,1,0,1);

    foreach (vecs[i]) begin
      rst_i     = vecs[i].rst;
      s_valid_i = vecs[i].valid;
      s_data_i  = 14'(vecs[i].data);
      tick();
      chk($sformatf("v%0d dac", i), int'($signed(dac_data_o)), LIN ? vecs[i].lin : vecs[i].zoh);
      chk($sformatf("v%0d underrun", i), int'(underrun_o), int'(vecs[i].und));
      chk($sformatf("v%0d running", i), int'(running_o), int'(vecs[i].run));
      chk($sformatf("v%0d ready", i), int'(s_ready_o), int'(vecs[i].rdy));
    end

    // Backpressure: valid held from the cycle before a boundary, FIFO fills
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    tick();
    n_acc = 0;
    for (int e = 0; e < 9; e++) begin
      chk($sformatf("bp ready e%0d", e), int'(s_ready_o), int'(bp_rdy[e]));
      s_valid_i = 1'b1;
      s_data_i  = 14'(bp_dat[n_acc]);
      if (s_ready_o) n_acc++;
      tick();
    end
    s_valid_i = 1'b0;
    chk("bp ready after pop", int'(s_ready_o), 1);
    chk("bp accepted", n_acc, 5);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        tick();
        tick();
        tick();
      end
      chk($sformatf("bp dac k%0d", k), int'($signed(dac_data_o)), LIN ? bp_lin[k] : bp_zoh[k]);
      chk($sformatf("bp running k%0d", k), int'(running_o), (k < 4) ? 1 : 0);
      chk($sformatf("bp underrun k%0d", k), int'(underrun_o), (k == 4) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
